// File: rtl/bus_gnrtr_n_rbtr_if.sv
// Device-side bus bundle for the packet arbiter: transmit FIFO heads in,
// pop/push strobes and the shared bus packet out.
interface bus_gnrtr_n_rbtr_if #(
   parameter int pckg_sz = 16,
   parameter int drvs    = 4
);
   logic [drvs-1:0]              pndng;
   logic [drvs-1:0][pckg_sz-1:0] D_pop;
   logic [drvs-1:0]              pop;
   logic [drvs-1:0]              push;
   logic [drvs-1:0][pckg_sz-1:0] D_push;

   modport master (
      input  pndng,
      input  D_pop,
      output pop,
      output push,
      output D_push
   );

   modport slave (
      output pndng,
      output D_pop,
      input  pop,
      input  push,
      input  D_push
   );
endinterface

// File: rtl/bus_gnrtr_n_rbtr.sv
// Round-robin bus arbiter: pops one pending device per transaction and pushes
// the packet to the device named in its top byte, or to all others on broadcast.
module bus_gnrtr_n_rbtr #(
   parameter int         pckg_sz   = 16,
   parameter int         drvs      = 4,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input logic                clk,
   input logic                reset,
   bus_gnrtr_n_rbtr_if.master bus
);

   localparam int IW = (drvs > 1) ? $clog2(drvs) : 1;

   typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [IW-1:0]        lastGrant_q, lastGrant_d;
   logic [pckg_sz-1:0]   packet_q, packet_d;
   logic [drvs-1:0]      pop_q, pop_d;
   logic [drvs-1:0]      push_q, push_d;
   logic [pckg_sz-1:0]   dPush_q, dPush_d;

   logic                 found;
   logic [IW-1:0]        sel;
   logic [IW-1:0]        scanIdx;
   logic [7:0]           dest;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= IW'(drvs - 1);
         packet_q    <= '0;
         pop_q       <= '0;
         push_q      <= '0;
         dPush_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         packet_q    <= packet_d;
         pop_q       <= pop_d;
         push_q      <= push_d;
         dPush_q     <= dPush_d;
      end
   end

   // Strobes are loaded one state early so they are high during POP and PUSH.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      packet_d    = packet_q;
      pop_d       = '0;
      push_d      = '0;
      dPush_d     = dPush_q;
      found       = 1'b0;
      sel         = '0;
      scanIdx     = '0;
      dest        = packet_q[pckg_sz-1 -: 8];

      for (int k = 1; k <= drvs; k++) begin
         scanIdx = IW'((int'(lastGrant_q) + k) % drvs);
         if (!found && bus.pndng[scanIdx]) begin
            found = 1'b1;
            sel   = scanIdx;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d     = sel;
               lastGrant_d = sel;
               packet_d    = bus.D_pop[sel];
               pop_d[sel]  = 1'b1;
               state_d     = POP;
            end
         end
         POP: begin
            dPush_d = packet_q;
            for (int j = 0; j < drvs; j++) begin
               if (dest == broadcast)
                  push_d[j] = (IW'(j) != grant_q);
               else if (int'(dest) == j)
                  push_d[j] = 1'b1;
            end
            state_d = PUSH;
         end
         PUSH:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.pop    = pop_q;
   assign bus.push   = push_q;
   assign bus.D_push = {drvs{dPush_q}};

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Directed bench for the bus arbiter with 8 devices and 16-bit packets.
module tb_bus_gnrtr_n_rbtr;

   localparam int PW = 16;
   localparam int ND = 8;

   logic clk;
   logic reset;
   int   checkCount;
   int   passCount;

   bus_gnrtr_n_rbtr_if #(.pckg_sz(PW), .drvs(ND)) busIf ();

   bus_gnrtr_n_rbtr #(.pckg_sz(PW), .drvs(ND), .broadcast(8'hFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // One full transaction from a single pending device, checked at every state.
   task automatic applyStimulus(input int src, input logic [PW-1:0] pkt,
                                input logic [ND-1:0] expPush);
      logic [ND-1:0] expPop;
      expPop = ND'(1) << src;
      busIf.pndng      = expPop;
      busIf.D_pop[src] = pkt;
      stepCycle();
      checkOutput($sformatf("pop src%0d", src), 128'(busIf.pop), 128'(expPop));
      checkOutput($sformatf("noPushInPop src%0d", src), 128'(busIf.push), 128'(0));
      busIf.pndng = '0;
      stepCycle();
      checkOutput($sformatf("popDone src%0d", src), 128'(busIf.pop), 128'(0));
      checkOutput($sformatf("push src%0d", src), 128'(busIf.push), 128'(expPush));
      checkOutput($sformatf("data src%0d", src), 128'(busIf.D_push), 128'({ND{pkt}}));
      stepCycle();
      checkOutput($sformatf("idleStrobes src%0d", src),
                  128'({busIf.pop, busIf.push}), 128'(0));
      checkOutput($sformatf("dataHeld src%0d", src), 128'(busIf.D_push), 128'({ND{pkt}}));
   endtask

   initial begin
      logic [PW-1:0] rrPkt;
      checkCount  = 0;
      passCount   = 0;
      reset       = 1'b0;
      busIf.pndng = '0;
      busIf.D_pop = '0;
      #2;
      checkOutput("resetPop", 128'(busIf.pop), 128'(0));
      checkOutput("resetPush", 128'(busIf.push), 128'(0));
      checkOutput("resetData", 128'(busIf.D_push), 128'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;

      applyStimulus(2, 16'h05AB, 8'b0010_0000);
      applyStimulus(0, 16'hFF12, 8'b1111_1110);
      applyStimulus(3, 16'h0A00, 8'b0000_0000);
      applyStimulus(4, 16'h0477, 8'b0001_0000);

      // Abort a transaction during POP; outputs must clear without a clock edge.
      busIf.pndng    = 8'b0010_0000;
      busIf.D_pop[5] = 16'h0133;
      stepCycle();
      checkOutput("midPopBeforeReset", 128'(busIf.pop), 128'(8'b0010_0000));
      #1;
      reset = 1'b0;
      #1;
      checkOutput("asyncPop", 128'(busIf.pop), 128'(0));
      checkOutput("asyncPush", 128'(busIf.push), 128'(0));
      checkOutput("asyncData", 128'(busIf.D_push), 128'(0));
      busIf.pndng = '0;

      for (int i = 0; i < ND; i++) busIf.D_pop[i] = PW'(16'h0010 * (i + 1));
      @(negedge clk);
      reset       = 1'b1;
      busIf.pndng = '1;

      // With everyone pending, grants must walk 0..7 and wrap back to 0.
      for (int k = 0; k <= ND; k++) begin
         rrPkt = PW'(16'h0010 * ((k % ND) + 1));
         stepCycle();
         checkOutput($sformatf("rrPop%0d", k), 128'(busIf.pop), 128'(ND'(1) << (k % ND)));
         stepCycle();
         checkOutput($sformatf("rrPush%0d", k), 128'(busIf.push), 128'(8'b0000_0001));
         checkOutput($sformatf("rrData%0d", k), 128'(busIf.D_push), 128'({ND{rrPkt}}));
         stepCycle();
         checkOutput($sformatf("rrIdle%0d", k), 128'({busIf.pop, busIf.push}), 128'(0));
      end
      busIf.pndng = '0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
